bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Shares one serial system bus between NUM_MASTERS master ports, using round-robin arbitration with a single bus owner at a time. The granted master's bus-side signals (mode, wr_bus, master_valid, master_ready) are muxed onto the shared bus. The slave-side responses (rd_bus, ack, slave_ready, slave_valid) are routed back only to the owner. A watchdog revokes ownership from a master that holds the bus with no handshake activity.

Parameters:
NUM_MASTERS, 2, number of requesting master ports (2..8)
TIMEOUT, 64, idle cycles with grant held and no handshake before forced revoke
MID_W, $clog2(NUM_MASTERS), width of owner index

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
m_req  in  NUM_MASTERS  per-master bus request, level, held for whole transaction
m_grant  out  NUM_MASTERS  one-hot grant
m_mode  in  NUM_MASTERS  per-master mode (1=write)
m_wr_bus  in  NUM_MASTERS  per-master serial write/address bit
m_master_valid  in  NUM_MASTERS  per-master valid
m_master_ready  in  NUM_MASTERS  per-master ready
m_rd_bus  out  NUM_MASTERS  serial read bit to each master
m_ack  out  NUM_MASTERS  slave address ack to each master
m_slave_ready  out  NUM_MASTERS  slave ready to each master
m_slave_valid  out  NUM_MASTERS  slave valid to each master
b_mode  out  1  shared bus mode
b_wr_bus  out  1  shared serial write/address line
b_master_valid  out  1  shared master valid
b_master_ready  out  1  shared master ready
b_rd_bus  in  1  shared serial read line
b_ack  in  1  shared ack
b_slave_ready  in  1  shared slave ready
b_slave_valid  in  1  shared slave valid
bus_busy  out  1  high in GRANT state
owner  out  MID_W  index of current/last owner
timeout_err  out  1  one-cycle pulse on watchdog revoke

Behaviour:
- Reset (async, rstn=0): state=IDLE, m_grant=0, owner=0, rr pointer=NUM_MASTERS-1, watchdog=0, timeout_err=0. All b_* outputs and all m_* outputs are 0 immediately.
- States:
  - IDLE: if any m_req is set, pick a winner and go to GRANT. The grant is registered, so m_grant rises 1 cycle after the req is sampled.
  - GRANT: stay while m_req[owner]=1 and watchdog<TIMEOUT. If m_req[owner] falls, go to RELEASE. If watchdog reaches TIMEOUT, pulse timeout_err and go to RELEASE.
  - RELEASE: one turnaround cycle with m_grant=0 and b_* outputs=0, then go to IDLE. Requests are not evaluated in RELEASE.
- Winner selection: the first asserted m_req searching upward from (pointer+1) mod NUM_MASTERS, wrapping around. On grant, owner=winner and pointer=winner.
- Minimum req-to-grant latency is 1 cycle. Back-to-back grants to different masters are separated by RELEASE plus IDLE, i.e. 2 cycles with no grant.
- Muxing: in GRANT, each b_* output equals the corresponding m_*[owner] bit. Outside GRANT, all b_* outputs are 0.
- Demux: m_rd_bus/m_ack/m_slave_ready/m_slave_valid[i] equal the b_* input when i==owner in GRANT, and 0 otherwise. These paths are combinational with no added latency.
- Watchdog:
  - Cleared on entry to GRANT and on any cycle where (b_master_valid & b_slave_ready) or (b_master_ready & b_slave_valid).
  - Otherwise increments in GRANT and saturates at TIMEOUT.
- A forced-revoked master keeps m_grant=0 while its req stays high. It re-competes only after it drops req for at least 1 cycle (a per-master block bit, cleared when its req is 0).
- A req withdrawn while in IDLE before grant is ignored; no grant is issued.
- Requests from a non-owner during GRANT are held pending and considered at the next IDLE.
- m_grant is always one-hot or zero.
- owner holds its last value outside GRANT.

Decomposition:
- bus_pkg holds: arb_state_t enum {IDLE, GRANT, RELEASE}, and default constants for NUM_MASTERS and TIMEOUT.
- One sub-module, rr_picker: combinational round-robin selector. Inputs are the req vector (masked by the block bits) and the pointer. Outputs are winner index and a valid flag.
- Mux/demux and the state machine live in bus_arbiter.

Test Plan:
- Single request: m_req=01 at cycle 0 -> m_grant=01 at cycle 1, bus_busy=1, b_wr_bus follows m_wr_bus[0]. Drop req at cycle 10 -> m_grant=00 at cycle 11, RELEASE at 11, IDLE at 12.
- Simultaneous requests from reset: m_req=11 -> master 0 granted first (pointer=1). After master 0 releases, m_grant=10 exactly 2 cycles later.
- Fairness: both masters request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 and owner matches.
- Response isolation: master 1 owns the bus, drive b_slave_valid=1, b_rd_bus=1 -> m_slave_valid=10, m_rd_bus=10, and master 0 sees all zeros.
- Watchdog: master 0 granted with no handshake for TIMEOUT=64 cycles -> timeout_err pulses once, grant drops, and master 0 is not regranted while its req stays high. Master 1's pending req is granted 2 cycles later.
- Reset mid-transaction: assert rstn=0 in GRANT between clock edges -> m_grant, all b_* and all m_* outputs go to 0 immediately. After release, no grant occurs until the next req.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the round-robin serial bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request searching upward from
// ptr+1, wrapping at NUM_MASTERS.
module rr_picker
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int MID_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MID_W-1:0]       ptr,
  output logic [MID_W-1:0]       winner,
  output logic                   valid
);

  logic [MID_W-1:0] idx_s;

  // Scan farthest offset first so the nearest request after ptr wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      idx_s = MID_W'((int'(ptr) + off) % NUM_MASTERS);
      if (req[idx_s]) begin
        winner = idx_s;
        valid  = 1'b1;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared serial bus: muxes the owner's master lines
// onto the bus, routes slave responses back to it, and revokes idle owners.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int MID_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic                   b_mode,
  output logic                   b_wr_bus,
  output logic                   b_master_valid,
  output logic                   b_master_ready,
  input  logic                   b_rd_bus,
  input  logic                   b_ack,
  input  logic                   b_slave_ready,
  input  logic                   b_slave_valid,
  output logic                   bus_busy,
  output logic [MID_W-1:0]       owner,
  output logic                   timeout_err
);

  localparam int               WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [MID_W-1:0] PTR_RST = MID_W'(NUM_MASTERS - 1);

  arb_state_t             state_r, state_s;
  logic [MID_W-1:0]       owner_r, ptr_r, winner_s;
  logic [WD_W-1:0]        wd_r;
  logic [NUM_MASTERS-1:0] grant_r, block_r, eligible_s;
  logic [NUM_MASTERS-1:0] owner_onehot_s, winner_onehot_s;
  logic                   timeout_err_r, win_valid_s, in_grant_s;
  logic                   owner_req_s, handshake_s, revoke_s, take_s;

  // Masters revoked by the watchdog sit out until they drop their request.
  assign eligible_s = m_req & ~block_r;

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .MID_W      (MID_W)
  ) u_picker (
    .req   (eligible_s),
    .ptr   (ptr_r),
    .winner(winner_s),
    .valid (win_valid_s)
  );

  // One-hot decode of the current owner and of the picker's winner.
  always_comb begin
    owner_onehot_s  = '0;
    winner_onehot_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner_onehot_s[i]  = (owner_r == MID_W'(i));
      winner_onehot_s[i] = (winner_s == MID_W'(i));
    end
  end

  assign in_grant_s     = (state_r == GRANT);
  assign owner_req_s    = |(m_req & owner_onehot_s);
  assign b_mode         = in_grant_s & (|(m_mode & owner_onehot_s));
  assign b_wr_bus       = in_grant_s & (|(m_wr_bus & owner_onehot_s));
  assign b_master_valid = in_grant_s & (|(m_master_valid & owner_onehot_s));
  assign b_master_ready = in_grant_s & (|(m_master_ready & owner_onehot_s));
  assign handshake_s    = (b_master_valid & b_slave_ready) | (b_master_ready & b_slave_valid);

  // Route slave responses to the owner only, with no added latency.
  always_comb begin
    m_rd_bus      = '0;
    m_ack         = '0;
    m_slave_ready = '0;
    m_slave_valid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (in_grant_s && owner_onehot_s[i]) begin
        m_rd_bus[i]      = b_rd_bus;
        m_ack[i]         = b_ack;
        m_slave_ready[i] = b_slave_ready;
        m_slave_valid[i] = b_slave_valid;
      end else begin
        m_rd_bus[i]      = 1'b0;
        m_ack[i]         = 1'b0;
        m_slave_ready[i] = 1'b0;
        m_slave_valid[i] = 1'b0;
      end
    end
  end

  // Next-state decode; a request drop has priority over a watchdog revoke.
  always_comb begin
    state_s  = state_r;
    revoke_s = 1'b0;
    take_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_s = GRANT;
          take_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          state_s = RELEASE;
        end else if (wd_r == WD_MAX) begin
          state_s  = RELEASE;
          revoke_s = 1'b1;
        end else begin
          state_s = GRANT;
        end
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ownership, pointer, grant, watchdog and block bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_r       <= '0;
      ptr_r         <= PTR_RST;
      grant_r       <= '0;
      wd_r          <= '0;
      block_r       <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= revoke_s;
      block_r       <= (block_r & m_req) | (revoke_s ? owner_onehot_s : '0);
      if (take_s) begin
        owner_r <= winner_s;
        ptr_r   <= winner_s;
        grant_r <= winner_onehot_s;
      end else if (state_s != GRANT) begin
        grant_r <= '0;
      end else begin
        grant_r <= grant_r;
      end
      if (take_s || !in_grant_s || handshake_s) begin
        wd_r <= '0;
      end else if (wd_r != WD_MAX) begin
        wd_r <= wd_r + WD_W'(1);
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  assign m_grant     = grant_r;
  assign owner       = owner_r;
  assign timeout_err = timeout_err_r;
  assign bus_busy    = in_grant_s;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed plus randomized checks of bus_arbiter against a cycle-level
// reference model of ownership, round-robin order and the watchdog.
module tb_bus_arbiter;

  localparam int N  = 2;
  localparam int T  = 64;
  localparam int MW = 1;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] m_req, m_grant, m_mode, m_wr_bus, m_master_valid, m_master_ready;
  logic [N-1:0] m_rd_bus, m_ack, m_slave_ready, m_slave_valid;
  logic         b_mode, b_wr_bus, b_master_valid, b_master_ready;
  logic         b_rd_bus, b_ack, b_slave_ready, b_slave_valid;
  logic         bus_busy, timeout_err;
  logic [MW-1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mo = owner holding the bus (-1 none), gap = turnaround
  // cycles left before requests are looked at again.
  int mo, gap, ptr, last, idle;
  bit blocked [N];
  bit terr;
  int grants [$];
  int pulses;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(T), .MID_W(MW)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_grant(m_grant),
    .m_mode(m_mode), .m_wr_bus(m_wr_bus), .m_master_valid(m_master_valid),
    .m_master_ready(m_master_ready), .m_rd_bus(m_rd_bus), .m_ack(m_ack),
    .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid),
    .b_mode(b_mode), .b_wr_bus(b_wr_bus), .b_master_valid(b_master_valid),
    .b_master_ready(b_master_ready), .b_rd_bus(b_rd_bus), .b_ack(b_ack),
    .b_slave_ready(b_slave_ready), .b_slave_valid(b_slave_valid),
    .bus_busy(bus_busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mo = -1; gap = 0; ptr = N - 1; last = 0; idle = 0; terr = 1'b0;
    for (int i = 0; i < N; i++) blocked[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit hs;
    int w;
    int c;
    logic [N-1:0] r;
    r = m_req;
    terr = 1'b0;
    if (mo >= 0) begin
      hs = (bit'(m_master_valid >> mo) & b_slave_ready) |
           (bit'(m_master_ready >> mo) & b_slave_valid);
      if (!bit'(r >> mo)) begin
        mo = -1; gap = 1;
      end else if (idle >= T) begin
        blocked[mo] = 1'b1; terr = 1'b1; mo = -1; gap = 1;
      end else begin
        idle = hs ? 0 : idle + 1;
      end
    end else if (gap > 0) begin
      gap--;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        c = (ptr + k) % N;
        if (w < 0 && bit'(r >> c) && !blocked[c]) w = c;
      end
      if (w >= 0) begin
        mo = w; ptr = w; last = w; idle = 0; grants.push_back(w);
      end
    end
    for (int i = 0; i < N; i++) if (!bit'(r >> i)) blocked[i] = 1'b0;
  endtask

  task automatic check_all(string tag);
    logic [N-1:0] eg;
    eg = (mo >= 0) ? (N'(1) << mo) : '0;
    chk({tag, ".grant"}, m_grant, eg);
    chk({tag, ".busy"}, bus_busy, mo >= 0);
    chk({tag, ".owner"}, owner, last);
    chk({tag, ".terr"}, timeout_err, terr);
    chk({tag, ".b_mode"}, b_mode, (mo >= 0) ? bit'(m_mode >> mo) : 1'b0);
    chk({tag, ".b_wr"}, b_wr_bus, (mo >= 0) ? bit'(m_wr_bus >> mo) : 1'b0);
    chk({tag, ".b_mv"}, b_master_valid, (mo >= 0) ? bit'(m_master_valid >> mo) : 1'b0);
    chk({tag, ".b_mr"}, b_master_ready, (mo >= 0) ? bit'(m_master_ready >> mo) : 1'b0);
    chk({tag, ".m_rd"}, m_rd_bus, eg & {N{b_rd_bus}});
    chk({tag, ".m_ack"}, m_ack, eg & {N{b_ack}});
    chk({tag, ".m_sr"}, m_slave_ready, eg & {N{b_slave_ready}});
    chk({tag, ".m_sv"}, m_slave_valid, eg & {N{b_slave_valid}});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(string tag);
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic drive_rand(bit quiet);
    m_mode         = N'($urandom);
    m_wr_bus       = N'($urandom);
    m_master_valid = N'($urandom);
    m_master_ready = N'($urandom);
    b_rd_bus       = 1'($urandom);
    b_ack          = 1'($urandom);
    if (quiet) begin
      b_slave_ready = 1'b0;
      b_slave_valid = 1'b0;
    end else begin
      b_slave_ready = ($urandom_range(0, 3) != 0);
      b_slave_valid = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int held;
    m_req = '0; m_mode = '0; m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0;
    b_rd_bus = 1'b0; b_ack = 1'b0; b_slave_ready = 1'b0; b_slave_valid = 1'b0;
    rstn = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Simultaneous requests straight out of reset: master 0 first.
    m_req = 2'b11;
    cyc("sim_idle");
    chk("sim_first_grant", m_grant, 2'b01);
    repeat (3) begin drive_rand(1'b0); cyc("sim_hold"); end
    m_req = 2'b10;
    cyc("sim_drop");
    chk("sim_gap1", m_grant, 2'b00);
    cyc("sim_rel");
    chk("sim_gap2", m_grant, 2'b00);
    cyc("sim_idle2");
    chk("sim_second_grant", m_grant, 2'b10);
    m_req = 2'b00;
    repeat (3) cyc("sim_end");

    // Single request with the write line following master 0.
    m_req = 2'b01;
    cyc("single_req");
    chk("single_grant", m_grant, 2'b01);
    for (int k = 0; k < 9; k++) begin
      drive_rand(1'b0);
      #1;
      chk("single_wr_follow", b_wr_bus, m_wr_bus[0]);
      cyc("single_hold");
    end
    m_req = 2'b00;
    cyc("single_drop");
    chk("single_release", bus_busy, 1'b0);
    cyc("single_rel");
    cyc("single_idle");

    // Response isolation while master 1 owns the bus.
    m_req = 2'b10;
    cyc("iso_req");
    b_slave_valid = 1'b1; b_rd_bus = 1'b1; b_ack = 1'b0; b_slave_ready = 1'b0;
    #1;
    chk("iso_slave_valid", m_slave_valid, 2'b10);
    chk("iso_rd_bus", m_rd_bus, 2'b10);
    cyc("iso_check");
    m_req = 2'b00;
    repeat (3) cyc("iso_end");

    // Fairness: both keep requesting, the owner ends each transaction.
    grants.delete();
    held = 0;
    for (int k = 0; k < 200 && grants.size() < 6; k++) begin
      drive_rand(1'b0);
      if (mo >= 0 && held >= 3) begin
        m_req = 2'b11 & ~(N'(1) << mo);
        held = 0;
      end else begin
        m_req = 2'b11;
        held = (mo >= 0) ? held + 1 : 0;
      end
      cyc("fair");
    end
    chk("fair_count", grants.size(), 6);
    for (int k = 1; k < grants.size(); k++) chk("fair_alternate", grants[k] != grants[k-1], 1'b1);
    m_req = 2'b00;
    repeat (4) cyc("fair_end");

    // Randomized requests and bus traffic.
    for (int k = 0; k < 400; k++) begin
      drive_rand(($urandom_range(0, 15) == 0));
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) m_req[i] = ~m_req[i];
      cyc("rand");
    end
    m_req = 2'b00;
    repeat (4) cyc("rand_end");

    // Watchdog: master 0 silent, master 1 pending behind it.
    drive_rand(1'b1);
    m_req = 2'b01;
    cyc("wd_req");
    chk("wd_grant0", m_grant, 2'b01);
    m_req = 2'b11;
    pulses = 0;
    for (int k = 0; k < 100 && !timeout_err; k++) begin
      drive_rand(1'b1);
      cyc("wd_wait");
      pulses += int'(timeout_err);
    end
    chk("wd_fired", timeout_err, 1'b1);
    chk("wd_revoked", m_grant, 2'b00);
    drive_rand(1'b1);
    cyc("wd_rel");
    pulses += int'(timeout_err);
    chk("wd_gap", m_grant, 2'b00);
    cyc("wd_idle");
    chk("wd_m1_grant", m_grant, 2'b10);
    m_req = 2'b01;
    for (int k = 0; k < 6; k++) begin
      cyc("wd_blocked");
      pulses += int'(timeout_err);
      chk("wd_no_regrant", m_grant[0], 1'b0);
    end
    chk("wd_single_pulse", pulses, 1);
    m_req = 2'b00;
    cyc("wd_unblock");
    m_req = 2'b01;
    repeat (2) cyc("wd_recompete");
    chk("wd_regrant", m_grant, 2'b01);

    // Asynchronous reset in the middle of a transaction.
    b_rd_bus = 1'b1; b_ack = 1'b1; b_slave_ready = 1'b1; b_slave_valid = 1'b1;
    m_mode = 2'b11; m_wr_bus = 2'b11; m_master_valid = 2'b11; m_master_ready = 2'b11;
    @(negedge clk);
    rstn = 1'b0;
    m_req = 2'b00;
    model_reset();
    #1;
    check_all("rst_mid");
    #2;
    rstn = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      cyc("rst_after");
      chk("rst_no_grant", m_grant, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
